// File: rtl/end_task_pkg.sv
// Shared constants and the index-width helper for the end_task trigger collector.
package end_task_pkg;

    localparam int GPIO_NUM_DEF = 32;
    localparam int CNT_W        = 32;

    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/end_task_prio.sv
// Lowest-set-bit priority encoder: o_valid when any bit is set, o_idx of the lowest one.
module end_task_prio #(
    parameter int N     = 32,
    parameter int IDX_W = 5
) (
    input  logic [N-1:0]     i_vec,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx
);

    always_comb begin
        o_valid = |i_vec;
        o_idx   = '0;
        // Scan downward so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (i_vec[i]) o_idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/end_task.sv
// LED rising-edge trigger collector with pending set, one-deep output stage and overflow flag.
// Optional accepted-event counter on cnt_o when END_TASK_CNT_EN is defined.
module end_task
    import end_task_pkg::*;
#(
    parameter  int GPIO_NUM = GPIO_NUM_DEF,
    localparam int IDX_W    = idx_w(GPIO_NUM)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic                clr_i,
    input  logic [GPIO_NUM-1:0] led_i,
    output logic                evt_valid_o,
    input  logic                evt_ready_i,
    output logic [IDX_W-1:0]    evt_idx_o,
    output logic [GPIO_NUM-1:0] pend_o,
`ifdef END_TASK_CNT_EN
    output logic [CNT_W-1:0]    cnt_o,
`endif
    output logic                ovf_o
);

    logic [GPIO_NUM-1:0] r_led_q;
    logic [GPIO_NUM-1:0] r_pend;
    logic                r_valid;
    logic [IDX_W-1:0]    r_idx;
    logic                r_ovf;

    logic [GPIO_NUM-1:0] w_rise;
    logic [GPIO_NUM-1:0] w_load_mask;
    logic                w_pv;
    logic [IDX_W-1:0]    w_pidx;
    logic                w_load;
    logic                w_accept;

    end_task_prio #(
        .N     (GPIO_NUM),
        .IDX_W (IDX_W)
    ) u_prio (
        .i_vec   (r_pend),
        .o_valid (w_pv),
        .o_idx   (w_pidx)
    );

    assign w_rise      = led_i & ~r_led_q & {GPIO_NUM{en_i}};
    assign w_load      = ~r_valid | evt_ready_i;
    assign w_accept    = r_valid & evt_ready_i;
    assign w_load_mask = (w_load && w_pv) ? (GPIO_NUM'(1) << w_pidx) : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_led_q <= '0;
            r_pend  <= '0;
            r_valid <= 1'b0;
            r_idx   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_led_q <= led_i;
            if (clr_i) begin
                r_pend  <= '0;
                r_valid <= 1'b0;
                r_ovf   <= 1'b0;
            end else begin
                // A rise on the bit being handed to the output stage re-arms it cleanly.
                r_pend <= (r_pend & ~w_load_mask) | w_rise;
                if (|(w_rise & r_pend & ~w_load_mask)) r_ovf <= 1'b1;
                if (w_load) begin
                    r_valid <= w_pv;
                    r_idx   <= w_pidx;
                end
            end
        end
    end

`ifdef END_TASK_CNT_EN
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (w_accept && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt_o = r_cnt;
`else
    logic w_unused;
    assign w_unused = w_accept;
`endif

    assign evt_valid_o = r_valid;
    assign evt_idx_o   = r_idx;
    assign pend_o      = r_pend;
    assign ovf_o       = r_ovf;

endmodule

// File: tb/tb_end_task.sv
// Directed testbench for end_task with an expected-event scoreboard queue.
module tb_end_task;

    localparam int N = 32;
    localparam int W = 5;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          en_i;
    logic          clr_i;
    logic [N-1:0]  led_i;
    logic          evt_valid_o;
    logic          evt_ready_i;
    logic [W-1:0]  evt_idx_o;
    logic [N-1:0]  pend_o;
    logic          ovf_o;
`ifdef END_TASK_CNT_EN
    logic [31:0]   cnt_o;
`endif

    int            checks   = 0;
    int            failures = 0;
    int            exp_q[$];
    int            acc_cnt  = 0;

    always #5 clk_i = ~clk_i;

    end_task #(.GPIO_NUM(N)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .en_i        (en_i),
        .clr_i       (clr_i),
        .led_i       (led_i),
        .evt_valid_o (evt_valid_o),
        .evt_ready_i (evt_ready_i),
        .evt_idx_o   (evt_idx_o),
        .pend_o      (pend_o),
`ifdef END_TASK_CNT_EN
        .cnt_o       (cnt_o),
`endif
        .ovf_o       (ovf_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Called at a negedge with inputs already driven: scores any handshake that
    // the next rising edge will complete, then advances one cycle.
    task automatic tick();
        int e;
        if (clr_i) begin
            acc_cnt = 0;
        end else if (evt_valid_o && evt_ready_i) begin
            if (exp_q.size() == 0) begin
                chk("spurious_evt", {63'd0, evt_valid_o}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("evt_idx", {59'd0, evt_idx_o}, e);
                acc_cnt++;
            end
        end
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic chk_cnt();
`ifdef END_TASK_CNT_EN
        chk("cnt", {32'd0, cnt_o}, acc_cnt);
`endif
    endtask

    initial begin
        rst_i = 1'b1; en_i = 1'b0; clr_i = 1'b0; led_i = '0; evt_ready_i = 1'b0;
        #3;
        chk("rst_valid", {63'd0, evt_valid_o}, 0);
        chk("rst_pend", {32'd0, pend_o}, 0);
        chk("rst_ovf", {63'd0, ovf_o}, 0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // single rise on bit 4, 2-cycle latency, hold then accept
        en_i = 1'b1; tick();
        led_i = 32'h0000_0010; exp_q.push_back(4); tick();
        chk("lat_pend", {32'd0, pend_o}, 32'h10);
        chk("lat_valid_early", {63'd0, evt_valid_o}, 0);
        tick();
        chk("lat_valid", {63'd0, evt_valid_o}, 1);
        chk("lat_idx", {59'd0, evt_idx_o}, 4);
        tick(); tick();
        chk("hold_valid", {63'd0, evt_valid_o}, 1);
        chk("hold_idx", {59'd0, evt_idx_o}, 4);
        evt_ready_i = 1'b1; tick();
        chk("acc_valid", {63'd0, evt_valid_o}, 0);
        chk_cnt();

        // simultaneous rises drain back-to-back in ascending order
        led_i = '0; tick();
        led_i = 32'h8000_0005;
        exp_q.push_back(0); exp_q.push_back(2); exp_q.push_back(31);
        tick(); tick();
        chk("b2b_first_valid", {63'd0, evt_valid_o}, 1);
        tick(); tick(); tick();
        chk("b2b_empty", {63'd0, evt_valid_o}, 0);
        chk("b2b_q", exp_q.size(), 0);
        chk_cnt();

        // coalesced re-trigger while pending sets overflow
        evt_ready_i = 1'b0; led_i = '0; tick();
        led_i = 32'h1; exp_q.push_back(0); tick(); tick();
        led_i = 32'h9; exp_q.push_back(3); tick();
        led_i = 32'h1; tick();
        led_i = 32'h9; tick();
        chk("ovf_set", {63'd0, ovf_o}, 1);
        chk("ovf_pend", {32'd0, pend_o}, 32'h8);
        chk("ovf_hold_idx", {59'd0, evt_idx_o}, 0);
        evt_ready_i = 1'b1; tick(); tick(); tick();
        chk("ovf_drain", {63'd0, evt_valid_o}, 0);
        chk("ovf_q", exp_q.size(), 0);
        chk("ovf_sticky", {63'd0, ovf_o}, 1);

        // clear dominates a same-cycle rise
        evt_ready_i = 1'b0; led_i = '0; tick();
        led_i = 32'h1; tick(); tick();
        led_i = 32'h301; tick();
        chk("clr_pre_pend", {32'd0, pend_o}, 32'h300);
        chk("clr_pre_valid", {63'd0, evt_valid_o}, 1);
        clr_i = 1'b1; led_i = 32'h303; tick();
        clr_i = 1'b0;
        chk("clr_pend", {32'd0, pend_o}, 0);
        chk("clr_valid", {63'd0, evt_valid_o}, 0);
        chk("clr_ovf", {63'd0, ovf_o}, 0);
        chk_cnt();

        // rise on the bit being loaded re-sets pend without overflow
        led_i = '0; tick();
        led_i = 32'h2; exp_q.push_back(1); tick(); tick();
        led_i = 32'h6; exp_q.push_back(2); tick();
        led_i = 32'h2; tick();
        led_i = 32'h6; evt_ready_i = 1'b1; exp_q.push_back(2); tick();
        chk("reload_pend", {32'd0, pend_o}, 32'h4);
        chk("reload_ovf", {63'd0, ovf_o}, 0);
        chk("reload_idx", {59'd0, evt_idx_o}, 2);
        tick(); tick();
        chk("reload_drain", {63'd0, evt_valid_o}, 0);
        chk("reload_q", exp_q.size(), 0);
        chk_cnt();

        // disabled rises and steady high levels are ignored
        en_i = 1'b0; led_i = '0; tick();
        led_i = 32'h80; tick();
        led_i = 32'h00; tick();
        led_i = 32'h80; tick();
        chk("dis_pend", {32'd0, pend_o}, 0);
        en_i = 1'b1; tick(); tick(); tick();
        chk("steady_pend", {32'd0, pend_o}, 0);
        chk("steady_valid", {63'd0, evt_valid_o}, 0);

        // asynchronous reset mid-stream, then level-high counts as rise
        evt_ready_i = 1'b0; led_i = '0; tick();
        led_i = 32'h10; tick(); tick();
        led_i = 32'h30; tick();
        chk("pre_rst_valid", {63'd0, evt_valid_o}, 1);
        #2 rst_i = 1'b1;
        #1;
        chk("arst_valid", {63'd0, evt_valid_o}, 0);
        chk("arst_pend", {32'd0, pend_o}, 0);
        acc_cnt = 0;
        chk_cnt();
        @(negedge clk_i);
        rst_i = 1'b0; evt_ready_i = 1'b1;
        exp_q.push_back(4); exp_q.push_back(5);
        tick(); tick(); tick(); tick();
        chk("post_rst_drain", {63'd0, evt_valid_o}, 0);
        chk("final_q", exp_q.size(), 0);
        chk_cnt();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
